// File: rtl/dual_pop_fifo.sv
// Circular-buffer FIFO exposing its two oldest entries, with single or dual pop per cycle.
// Define DUAL_POP_FIFO_ERR_EN to add the sticky err_o flag for illegal push/pop requests.
module dual_pop_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter type         dtype      = logic [DATA_WIDTH-1:0]
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  dtype                       data_i,
    input  logic                       push_i,
    output dtype                       data_o0,
    output logic                       valid_o0,
    input  logic                       pop_i0,
    output dtype                       data_o1,
    output logic                       valid_o1,
    input  logic                       pop_i1,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
`ifdef DUAL_POP_FIFO_ERR_EN
    ,
    output logic                       err_o
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned SUM_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [SUM_W-1:0] DEPTH_S  = SUM_W'(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    dtype mem [DEPTH];
    ptr_t wr_ptr;
    ptr_t rd_ptr;
    cnt_t count;

    logic push_acc;
    logic pop0_acc;
    logic pop1_acc;
    logic has_one;
    logic has_two;
    logic is_full;

    // Pointer advance modulo DEPTH, valid for non-power-of-two depths too.
    function automatic ptr_t wrap_add(input ptr_t p, input logic [1:0] n);
        logic [SUM_W-1:0] s;
        s = {1'b0, p} + SUM_W'(n);
        if (s >= DEPTH_S) begin
            s = s - DEPTH_S;
        end
        return s[PTR_W-1:0];
    endfunction

    assign has_one = (count >= cnt_t'(1));
    assign has_two = (count >= cnt_t'(2));
    assign is_full = (count == FULL_CNT);

    assign push_acc = push_i && !is_full;
    assign pop0_acc = pop_i0 && has_one;
    assign pop1_acc = pop_i0 && pop_i1 && has_two;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wrap_add(wr_ptr, {1'b0, push_acc});
            rd_ptr <= wrap_add(rd_ptr, 2'(pop0_acc) + 2'(pop1_acc));
            count  <= count + cnt_t'(push_acc) - cnt_t'(pop0_acc) - cnt_t'(pop1_acc);
        end
    end

    // NOTE: storage has no reset; the cleared count keeps stale entries from ever being shown as valid.
    always_ff @(posedge clk_i) begin
        if (push_acc && !flush_i) begin
            mem[wr_ptr] <= data_i;
        end
    end

    assign data_o0  = mem[rd_ptr];
    assign data_o1  = mem[wrap_add(rd_ptr, 2'd1)];
    assign valid_o0 = has_one;
    assign valid_o1 = has_two;
    assign full_o   = is_full;
    assign empty_o  = (count == '0);
    assign count_o  = count;

`ifdef DUAL_POP_FIFO_ERR_EN
    logic err_q;
    logic err_req;

    assign err_req = (push_i && is_full) || (pop_i0 && !has_one)
                   || (pop_i1 && !pop0_acc) || (pop_i1 && !has_two);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (flush_i) begin
            err_q <= 1'b0;
        end else if (err_req) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_dual_pop_fifo.sv
// Scoreboard bench for dual_pop_fifo (DEPTH=4, DATA_WIDTH=32): a reference queue predicts every output.
module tb_dual_pop_fifo;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] data_in;
    logic        push;
    logic [31:0] data_o0;
    logic        valid_o0;
    logic        pop0;
    logic [31:0] data_o1;
    logic        valid_o1;
    logic        pop1;
    logic        full;
    logic        empty;
    logic [2:0]  count;
`ifdef DUAL_POP_FIFO_ERR_EN
    logic        err;
`endif

    dual_pop_fifo #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .data_i  (data_in),
        .push_i  (push),
        .data_o0 (data_o0),
        .valid_o0(valid_o0),
        .pop_i0  (pop0),
        .data_o1 (data_o1),
        .valid_o1(valid_o1),
        .pop_i1  (pop1),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
`ifdef DUAL_POP_FIFO_ERR_EN
        ,
        .err_o   (err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic        exp_err  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every observable output against the reference queue.
    task automatic check_state(input string tag);
        int n;
        n = exp_q.size();
        check({tag, ".count"}, 64'(count), 64'(n));
        check({tag, ".empty"}, 64'(empty), 64'(n == 0));
        check({tag, ".full"}, 64'(full), 64'(n == DEPTH));
        check({tag, ".valid0"}, 64'(valid_o0), 64'(n >= 1));
        check({tag, ".valid1"}, 64'(valid_o1), 64'(n >= 2));
        if (n >= 1) check({tag, ".data0"}, 64'(data_o0), 64'(exp_q[0]));
        if (n >= 2) check({tag, ".data1"}, 64'(data_o1), 64'(exp_q[1]));
`ifdef DUAL_POP_FIFO_ERR_EN
        check({tag, ".err"}, 64'(err), 64'(exp_err));
`endif
    endtask

    // One clock cycle of stimulus; called just after a rising edge.
    task automatic step(input string tag, input logic ps, input logic [31:0] d,
                        input logic p0, input logic p1, input logic fl);
        int   n;
        logic pu_a, p0_a, p1_a;
        push = ps; data_in = d; pop0 = p0; pop1 = p1; flush = fl;
        @(negedge clk);
        check_state(tag);
        n    = exp_q.size();
        pu_a = ps && (n < DEPTH);
        p0_a = p0 && (n >= 1);
        p1_a = p0 && p1 && (n >= 2);
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
            exp_err = 1'b0;
        end else begin
            if ((ps && n == DEPTH) || (p0 && n == 0) || (p1 && !p0_a) || (p1 && n < 2))
                exp_err = 1'b1;
            if (p0_a) void'(exp_q.pop_front());
            if (p1_a) void'(exp_q.pop_front());
            if (pu_a) exp_q.push_back(d);
        end
        push = 1'b0; pop0 = 1'b0; pop1 = 1'b0; flush = 1'b0; data_in = '0;
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; push = 1'b0; pop0 = 1'b0; pop1 = 1'b0; data_in = '0;
        #2;
        check_state("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Three pushes, then a dual pop with a concurrent push.
        step("push_a", 1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        step("push_b", 1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        step("push_c", 1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        check("abc.count", 64'(count), 64'd3);
        check("abc.data0", 64'(data_o0), 64'hA);
        check("abc.data1", 64'(data_o1), 64'hB);
        step("dual_push", 1'b1, 32'hD, 1'b1, 1'b1, 1'b0);
        check("cd.count", 64'(count), 64'd2);
        check("cd.data0", 64'(data_o0), 64'hC);
        check("cd.data1", 64'(data_o1), 64'hD);

        // Full: a push in the same cycle as a pop is dropped.
        step("fill1", 1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
        step("fill2", 1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        step("full_pp", 1'b1, 32'hE, 1'b1, 1'b0, 1'b0);
        check("drop.count", 64'(count), 64'd3);
        check("drop.full", 64'(full), 64'd0);
`ifdef DUAL_POP_FIFO_ERR_EN
        check("drop.err", 64'(err), 64'd1);
`endif

        // Wrap: steer rd_ptr to 3 with two entries, dual pop, then push.
        step("wflush", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step("wpush", 1'b1, 32'(i + 1), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("wpop", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step("wpush4", 1'b1, 32'h4, 1'b0, 1'b0, 1'b0);
        step("wpush5", 1'b1, 32'h6, 1'b0, 1'b0, 1'b0);
        step("wdual", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        check("wrap.empty", 64'(empty), 64'd1);
        step("wpost", 1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
        check("wrap.data0", 64'(data_o0), 64'h5);
        check("wrap.valid0", 64'(valid_o0), 64'd1);

        // Dual pop with one entry, then pop_i1 alone at count 3.
        step("one_dual", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        check("one.empty", 64'(empty), 64'd1);
        for (int i = 0; i < 3; i++) step("p1fill", 1'b1, 32'h20 + 32'(i), 1'b0, 1'b0, 1'b0);
        step("p1_only", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("p1.count", 64'(count), 64'd3);

        // Flush overrides a same-cycle push and pop.
        step("flush_pp", 1'b1, 32'h99, 1'b1, 1'b0, 1'b1);
        check("flush.count", 64'(count), 64'd0);
        check("flush.empty", 64'(empty), 64'd1);

        // Random traffic, push-heavy then pop-heavy.
        for (int i = 0; i < 400; i++) begin
            int push_pct;
            push_pct = (i < 200) ? 70 : 35;
            step("rand", ($urandom_range(0, 99) < push_pct), $urandom,
                 ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 99) < 3));
        end

        // Asynchronous reset mid-stream, observed without a clock edge.
        for (int i = 0; i < 3; i++) step("rfill", 1'b1, 32'h30 + 32'(i), 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        check("rst.count", 64'(count), 64'd0);
        check("rst.empty", 64'(empty), 64'd1);
        check("rst.full", 64'(full), 64'd0);
        check("rst.valid0", 64'(valid_o0), 64'd0);
        check("rst.valid1", 64'(valid_o1), 64'd0);
        exp_q.delete();
        exp_err = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle("post_rst");
        step("post_push", 1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
        idle("post_chk");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
